// File: rtl/fpu_pkg.sv
// Shared FP32 field layout, conversion constants and FSM encoding for the
// float-to-integer converter.
package fpu_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  localparam logic [FP_EXP_W-1:0] FP_BIAS   = 8'd127;
  // Exponent at which the 24-bit significand already sits at integer scale.
  localparam logic [FP_EXP_W-1:0] EXP_ALIGN = 8'd150;
  localparam logic [FP_EXP_W-1:0] EXP_SAT   = 8'd158;
  localparam logic [FP_EXP_W-1:0] EXP_ALL1  = 8'hFF;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_cls_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SHIFT,
    ST_SIGN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational split of an FP32 word into fields and IEEE-754 class.
// Zero latency; no flow control.
module fp32_unpack
  import fpu_pkg::*;
(
  input  logic [31:0] f_in,
  output fp32_t       fields,
  output fp_cls_t     cls
);

  always_comb begin
    fields = fp32_t'(f_in);
    cls    = CLS_NORMAL;
    if (fields.exp == '0) begin
      cls = (fields.frac == '0) ? CLS_ZERO : CLS_DENORM;
    end else if (fields.exp == EXP_ALL1) begin
      cls = (fields.frac == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp32_to_int32.sv
// FP32 to int32 converter, truncating toward zero, with a bit-serial shifter.
// done pulses 3+k cycles after acceptance; start is ignored unless idle.
module fp32_to_int32
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] F1,
  output logic        busy,
  output logic        done,
  output logic [31:0] I3,
  output logic        invalid,
  output logic        inexact
);

  state_t      state_q, state_d;
  logic [31:0] f1_q, f1_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  k_q, k_d;
  logic        left_q, left_d;
  logic        sticky_q, sticky_d;
  logic        inv_q, inv_d;
  logic [31:0] i3_q, i3_d;
  logic        invalid_q, invalid_d;
  logic        inexact_q, inexact_d;

  fp32_t       fields;
  fp_cls_t     cls;
  logic [7:0]  exp_up;
  logic [7:0]  exp_dn;

  fp32_unpack u_unpack (
    .f_in   (f1_q),
    .fields (fields),
    .cls    (cls)
  );

  assign exp_up = fields.exp - EXP_ALIGN;
  assign exp_dn = EXP_ALIGN - fields.exp;

  always_comb begin
    state_d   = state_q;
    f1_d      = f1_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    k_d       = k_q;
    left_d    = left_q;
    sticky_d  = sticky_q;
    inv_d     = inv_q;
    i3_d      = i3_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          f1_d    = F1;
          state_d = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        sign_d   = fields.sign;
        mag_d    = '0;
        k_d      = '0;
        left_d   = 1'b0;
        sticky_d = 1'b0;
        inv_d    = 1'b0;
        state_d  = ST_SIGN;
        case (cls)
          CLS_ZERO, CLS_DENORM: sticky_d = |fields.frac;
          CLS_INF:              inv_d    = 1'b1;
          CLS_NAN: begin
            inv_d  = 1'b1;
            sign_d = 1'b0;
          end
          default: begin
            if (fields.exp < FP_BIAS) begin
              sticky_d = 1'b1;
            end else if (fields.exp < EXP_SAT) begin
              mag_d  = {8'b0, 1'b1, fields.frac};
              left_d = (fields.exp > EXP_ALIGN);
              k_d    = left_d ? exp_up[4:0] : exp_dn[4:0];
              if (k_d != '0) state_d = ST_SHIFT;
            end else if (fields.exp == EXP_SAT && fields.sign && fields.frac == '0) begin
              // -2^31 is representable; negation in SIGN leaves it unchanged.
              mag_d = INT_MIN;
            end else begin
              inv_d = 1'b1;
            end
          end
        endcase
      end

      ST_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
        end
        k_d = k_q - 5'd1;
        if (k_q == 5'd1) state_d = ST_SIGN;
      end

      ST_SIGN: begin
        if (inv_q) begin
          i3_d = sign_q ? INT_MIN : INT_MAX;
        end else begin
          i3_d = sign_q ? -mag_q : mag_q;
        end
        invalid_d = inv_q;
        inexact_d = sticky_q;
        state_d   = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      f1_q      <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      k_q       <= '0;
      left_q    <= 1'b0;
      sticky_q  <= 1'b0;
      inv_q     <= 1'b0;
      i3_q      <= '0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      f1_q      <= f1_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      k_q       <= k_d;
      left_q    <= left_d;
      sticky_q  <= sticky_d;
      inv_q     <= inv_d;
      i3_q      <= i3_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
    end
  end

  assign busy    = (state_q == ST_UNPACK) || (state_q == ST_SHIFT) || (state_q == ST_SIGN);
  assign done    = (state_q == ST_DONE);
  assign I3      = i3_q;
  assign invalid = invalid_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_fp32_to_int32.sv
// Directed-vector bench for fp32_to_int32 with hand-computed results.
module tb_fp32_to_int32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] F1;
  logic        busy;
  logic        done;
  logic [31:0] I3;
  logic        invalid;
  logic        inexact;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] f;
    logic [31:0] i3;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  fp32_to_int32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .F1      (F1),
    .busy    (busy),
    .done    (done),
    .I3      (I3),
    .invalid (invalid),
    .inexact (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // Accepts one operand in an IDLE cycle and waits for done; returns in the
  // cycle after done, i.e. IDLE again, so consecutive calls are back-to-back.
  task automatic run_vec(input string tag, input logic [31:0] f, input logic [31:0] exp_i3,
                         input logic exp_inv, input logic exp_inx, input int exp_lat);
    int cnt;
    @(negedge clk);
    F1    = f;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    F1    = 32'hDEAD_BEEF;
    cnt   = 1;
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
    while (!done && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq({tag, "_lat"}, cnt, exp_lat);
    check_eq({tag, "_i3"}, I3, exp_i3);
    check_eq({tag, "_inv"}, {31'b0, invalid}, {31'b0, exp_inv});
    check_eq({tag, "_inx"}, {31'b0, inexact}, {31'b0, exp_inx});
    check_eq({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int cnt;
    int done_seen;
    n_checks = 0;
    n_fail   = 0;

    vecs = '{
      '{32'h42F6_0000, 32'h0000_007B, 1'b0, 1'b0, 20},  // 123.0
      '{32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 20},  // -123.0
      '{32'h3F40_0000, 32'h0000_0000, 1'b0, 1'b1, 3},   // 0.75
      '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 10},  // largest below 2^31
      '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0, 1'b0, 3},   // exponent 150, no shift
      '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 3},   // -2^31 exact
      '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 3},   // +2^31 overflow
      '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 3},   // NaN
      '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 3},   // -inf
      '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 3},   // +inf
      '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 3},   // -0
      '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 3},   // smallest denormal
      '{32'hCF80_0000, 32'h8000_0000, 1'b1, 1'b0, 3},   // -2^32
      '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 3},   // just below -2^31
      '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 26},  // 1.0
      '{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 26},  // 1.5
      '{32'hBF80_0001, 32'hFFFF_FFFF, 1'b1 & 1'b0, 1'b1, 26}  // -1.0000001
    };

    // Reset with start held high: nothing may be accepted.
    rst_n = 1'b0;
    start = 1'b1;
    F1    = 32'h42F6_0000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_i3", I3, 32'd0);
    check_eq("rst_inv", {31'b0, invalid}, 32'd0);
    check_eq("rst_inx", {31'b0, inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_busy", {31'b0, busy}, 32'd0);

    foreach (vecs[i]) begin
      run_vec($sformatf("v%0d", i), vecs[i].f, vecs[i].i3, vecs[i].inv, vecs[i].inx, vecs[i].lat);
    end

    // Result holds through idle cycles.
    repeat (4) @(posedge clk);
    #1;
    check_eq("hold_i3", I3, 32'hFFFF_FFFF);
    check_eq("hold_inx", {31'b0, inexact}, 32'd1);

    // start re-pulsed mid-SHIFT is ignored.
    @(negedge clk);
    F1    = 32'h42F6_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt   = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    F1    = 32'h4B7F_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    cnt++;
    start = 1'b0;
    while (!done && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq("ign_lat", cnt, 20);
    check_eq("ign_i3", I3, 32'h0000_007B);
    check_eq("ign_inx", {31'b0, inexact}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("ign_no_restart", {31'b0, busy}, 32'd0);

    // Make flags nonzero, then reset mid-SHIFT of a following operation.
    run_vec("pre_abort", 32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 26);
    @(negedge clk);
    F1    = 32'hC2F6_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_done", {31'b0, done}, 32'd0);
    check_eq("abort_i3", I3, 32'd0);
    check_eq("abort_inv", {31'b0, invalid}, 32'd0);
    check_eq("abort_inx", {31'b0, inexact}, 32'd0);
    rst_n     = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check_eq("abort_no_done", done_seen, 0);
    check_eq("abort_i3_after", I3, 32'd0);

    // Operation after abort still works.
    run_vec("after_abort", 32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
